// File: rtl/onehot_decoder_buf_if.sv
// Handshake bundle for onehot_decoder_buf: code input side, one-hot output side, occupancy.
interface onehot_decoder_buf_if #(
    parameter int unsigned IN_W  = 3,
    parameter int unsigned OUT_W = 1 << IN_W,
    parameter int unsigned DEPTH = 2
);
    logic                     in_valid;
    logic                     in_ready;
    logic [IN_W-1:0]          in_code;
    logic                     out_valid;
    logic                     out_ready;
    logic [OUT_W-1:0]         out_d;
    logic [$clog2(DEPTH):0]   occupancy;

    modport master (
        output in_valid, in_code, out_ready,
        input  in_ready, out_valid, out_d, occupancy
    );

    modport slave (
        input  in_valid, in_code, out_ready,
        output in_ready, out_valid, out_d, occupancy
    );
endinterface

// File: rtl/onehot_decoder_buf.sv
// Binary-to-one-hot decoder with a DEPTH-entry FIFO between valid/ready handshakes.
// Optional ONEHOT_DECODER_STICKY_EN adds an accumulated mask of every popped word.
module onehot_decoder_buf #(
    parameter int unsigned IN_W  = 3,
    parameter int unsigned OUT_W = 1 << IN_W,
    parameter int unsigned DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
`ifdef ONEHOT_DECODER_STICKY_EN
    input  logic             sticky_clr,
    output logic [OUT_W-1:0] sticky_mask,
`endif
    onehot_decoder_buf_if.slave bus
);
    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    logic [OUT_W-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             push, pop;
    logic [OUT_W-1:0] push_word;
    logic [OUT_W-1:0] head_word;

    // No pass-through when full: readiness depends only on stored count.
    assign bus.in_ready  = (cnt_q < CntW'(DEPTH)) && !rst;
    assign bus.out_valid = (cnt_q != '0);
    assign head_word     = mem_q[rd_ptr_q];
    assign bus.out_d     = bus.out_valid ? head_word : '0;
    assign bus.occupancy = cnt_q;

    assign push      = bus.in_valid && bus.in_ready;
    assign pop       = bus.out_valid && bus.out_ready;
    assign push_word = OUT_W'(1) << bus.in_code;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
        unique case ({push, pop})
            2'b10:   cnt_d = cnt_q + CntW'(1);
            2'b01:   cnt_d = cnt_q - CntW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            mem_q    <= '{default: '0};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            if (push) mem_q[wr_ptr_q] <= push_word;
        end
    end

`ifdef ONEHOT_DECODER_STICKY_EN
    logic [OUT_W-1:0] sticky_q, sticky_d;

    // Clear takes priority over recording a coincident pop.
    always_comb begin
        sticky_d = sticky_q;
        if (sticky_clr)  sticky_d = '0;
        else if (pop)    sticky_d = sticky_q | head_word;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) sticky_q <= '0;
        else     sticky_q <= sticky_d;
    end

    assign sticky_mask = sticky_q;
`endif
endmodule

// File: doc/onehot_decoder_buf.md
Name: onehot_decoder_buf

Overview:
- Reverse direction of the team's priority-free 8:3 OR encoder: takes a binary code and produces the matching one-hot vector.
- Registered, with valid/ready handshakes on both sides and a DEPTH-entry output buffer, so a stalled consumer never drops a code.
- Sits between a code producer (encoder side or control logic) and a one-hot consumer (line enables, select strobes).

Parameters:
- IN_W, 3, code width in bits.
- OUT_W, 1<<IN_W (8), one-hot output width. Must equal 2**IN_W.
- DEPTH, 2, buffer entries. Must be a power of 2, >= 2.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  reset, asynchronous, active-high; clears all state immediately.
- in_valid  input  1  in_code is valid this cycle.
- in_ready  output  1  block can accept a code this cycle.
- in_code  input  IN_W  binary code; value k selects bit k.
- out_valid  output  1  out_d holds a buffered one-hot word.
- out_ready  input  1  consumer accepts out_d this cycle.
- out_d  output  OUT_W  one-hot word at the buffer head; all zeros when out_valid=0.
- occupancy  output  clog2(DEPTH)+1  number of entries currently buffered.

Behaviour:
- Decode rule: entry = (1 << in_code). Exactly one bit is set for every legal code. There are no illegal codes, since OUT_W = 2**IN_W.
- Input transfer: occurs on the rising edge where in_valid && in_ready.
- Output transfer: occurs on the rising edge where out_valid && out_ready.
- in_ready = (occupancy < DEPTH) && !rst. This is combinational from registered state. There is no pass-through when full: a pop in the same cycle does not raise in_ready.
- out_valid = (occupancy != 0), registered-state derived. out_d is driven from the head-entry register.
- Latency: a code accepted at edge N is visible on out_d/out_valid after edge N when the buffer was empty. It is never visible combinationally in the same cycle.
- Simultaneous push and pop with 0 < occupancy < DEPTH: occupancy is unchanged, order is preserved, and the new entry goes behind the existing ones.
- Push only: occupancy += 1. Pop only: occupancy -= 1.
- Pop when empty is impossible, because out_valid=0 blocks it.
- Write and read pointers are each IN-buffer indices of clog2(DEPTH) bits and wrap modulo DEPTH with no gap.
- FIFO ordering is strict: codes leave in acceptance order.
- in_code is ignored whenever in_valid=0 or in_ready=0. A producer holding in_valid while in_ready=0 must keep in_code stable (protocol rule). The block does not check it.
- out_d is stable while out_valid=1 && out_ready=0.
- Reset (async, any time, including mid-transfer):
  - occupancy=0, out_valid=0, out_d=0, in_ready=0 while rst=1, pointers=0, buffered entries discarded.
  - On the first edge after rst deasserts, in_ready=1.
  - A handshake coincident with rst=1 is lost.

Optional Feature:
- Macro: ONEHOT_DECODER_STICKY_EN.
- Defined:
  - Adds input sticky_clr (1) and output sticky_mask (OUT_W).
  - sticky_mask accumulates the OR of every word popped at the output (on out_valid && out_ready).
  - sticky_clr=1 zeroes the mask at the next edge. If a pop coincides with sticky_clr, clear wins and the popped word is not recorded.
  - Reset value is 0.
- Not defined: both ports and the logic are absent. The core behaviour is identical.

Test Plan:
- Reset then sweep: apply in_code 0..7 one per cycle with out_ready=1 -> out_d = 0x01,0x02,...,0x80, each one cycle after acceptance; occupancy never exceeds 1.
- Backpressure fill: out_ready=0, push 3 then 6 -> occupancy=2, in_ready=0. Third code 5 is held and not accepted. Release out_ready -> out_d 0x08 then 0x40 then 0x20, in order.
- Simultaneous push/pop at occupancy=1 (head 0x02, push code 7, out_ready=1) -> occupancy stays 1, next out_d=0x80.
- Async reset mid-stream with occupancy=2 -> out_valid=0, out_d=0, occupancy=0 immediately without waiting for clk; in_ready=1 after the first edge post-deassert; stale entries never appear.
- Pointer wrap: 20 random codes with random out_ready (about 50%) against a scoreboard -> order and values match exactly, and out_d holds stable during every stall.
- With ONEHOT_DECODER_STICKY_EN: pop codes 1,4,4 -> sticky_mask=0x12. sticky_clr coincident with a pop of code 7 -> sticky_mask=0x00 next cycle.
